// File: rtl/stage_write_arb.sv
// Writeback arbiter: the MW pipeline slot owns the regfile write port; multi-cycle results
// queue in a small FIFO and drain on idle cycles. Optional macro WB_MD_BYPASS_EN.
module stage_write_arb #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STATUS_REG = 30,
  parameter int unsigned LINK_REG   = 31
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [31:0]                 insn_in,
  input  logic [DATA_W-1:0]           o_in,
  input  logic [DATA_W-1:0]           d_in,
  input  logic                        write_exception,
  input  logic                        md_valid,
  output logic                        md_ready,
  input  logic [DATA_W-1:0]           md_data,
  input  logic [REG_AW-1:0]           md_dest,
  input  logic                        md_exception,
  output logic [DATA_W-1:0]           data_writeReg,
  output logic [REG_AW-1:0]           ctrl_writeReg,
  output logic                        ctrl_writeEnable,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic [(2**REG_AW)-1:0]      pending_mask
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 2**REG_AW;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ALT  = 5'b01100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] data;
  } md_entry_t;

  logic [4:0]        opcode;
  logic              pipe_writes;
  logic              pipe_we;
  logic [REG_AW-1:0] pipe_dest;
  logic [DATA_W-1:0] pipe_data;
  logic [REG_AW-1:0] md_dest_f;
  logic              full;
  logic              empty;
  logic              md_accept;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              write_en;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  md_entry_t         mem_q [DEPTH];

  logic              unused_insn;
  assign unused_insn = ^insn_in[21:0];

  // Pipeline decode
  assign opcode = insn_in[31:27];

  always_comb begin
    pipe_writes = 1'b0;
    case (opcode)
      OP_R, OP_ALT, OP_ADDI, OP_LW, OP_JAL, OP_SETX: pipe_writes = 1'b1;
      default: pipe_writes = 1'b0;
    endcase
  end

  always_comb begin
    pipe_dest = insn_in[26:22];
    if (opcode == OP_JAL) begin
      pipe_dest = REG_AW'(LINK_REG);
    end else if (write_exception || (opcode == OP_SETX)) begin
      pipe_dest = REG_AW'(STATUS_REG);
    end
  end

  assign pipe_data = (opcode == OP_LW) ? d_in : o_in;
  assign pipe_we   = pipe_writes & (pipe_dest != '0);

  // md channel handshake; r0 destinations are accepted but dropped
  assign md_dest_f = md_exception ? REG_AW'(STATUS_REG) : md_dest;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign md_ready  = ~full;
  assign md_accept = md_valid & ~full & (md_dest_f != '0);

`ifdef WB_MD_BYPASS_EN
  assign bypass = empty & ~pipe_we & md_accept;
`else
  assign bypass = 1'b0;
`endif

  assign push = md_accept & ~bypass;
  assign pop  = ~pipe_we & ~empty;

  // Write-port mux: pipeline, then FIFO head, then bypassed md result
  always_comb begin
    data_writeReg = o_in;
    ctrl_writeReg = pipe_dest;
    write_en      = 1'b0;
    if (pipe_we) begin
      data_writeReg = pipe_data;
      ctrl_writeReg = pipe_dest;
      write_en      = 1'b1;
    end else if (!empty) begin
      data_writeReg = mem_q[rd_ptr_q].data;
      ctrl_writeReg = mem_q[rd_ptr_q].dest;
      write_en      = 1'b1;
    end else if (bypass) begin
      data_writeReg = md_data;
      ctrl_writeReg = md_dest_f;
      write_en      = 1'b1;
    end
  end

  assign ctrl_writeEnable = write_en & ~reset;

  // FIFO bookkeeping next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset; the valid bits gate everything that reads it
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{dest: md_dest_f, data: md_data};
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i]) begin
        pending_mask[mem_q[i].dest] = 1'b1;
      end
    end
  end

  assign fifo_count = count_q;

  logic unused_nreg;
  assign unused_nreg = (NREG == 0);

endmodule

// File: tb/tb_stage_write_arb.sv
// Bench for stage_write_arb: directed plan steps then randomized traffic, all checked
// against a queue-based reference model of the writeback rules.
module tb_stage_write_arb;

  localparam int unsigned DEPTH = 4;
`ifdef WB_MD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] insn_in = '0;
  logic [31:0] o_in = '0;
  logic [31:0] d_in = '0;
  logic        write_exception = 1'b0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [31:0] md_data = '0;
  logic [4:0]  md_dest = '0;
  logic        md_exception = 1'b0;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_writeReg;
  logic        ctrl_writeEnable;
  logic [2:0]  fifo_count;
  logic [31:0] pending_mask;

  stage_write_arb #(.DATA_W(32), .REG_AW(5), .DEPTH(DEPTH), .STATUS_REG(30), .LINK_REG(31)) dut (
    .clock(clock), .reset(reset), .insn_in(insn_in), .o_in(o_in), .d_in(d_in),
    .write_exception(write_exception), .md_valid(md_valid), .md_ready(md_ready),
    .md_data(md_data), .md_dest(md_dest), .md_exception(md_exception),
    .data_writeReg(data_writeReg), .ctrl_writeReg(ctrl_writeReg),
    .ctrl_writeEnable(ctrl_writeEnable), .fifo_count(fifo_count), .pending_mask(pending_mask)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  bit          m_we, m_byp, m_pw;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic [4:0]  wops[6] = '{5'd0, 5'd12, 5'd5, 5'd8, 5'd3, 5'd21};
  logic [4:0]  nops[6] = '{5'd2, 5'd1, 5'd4, 5'd7, 5'd16, 5'd31};

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] md_final();
    return md_exception ? 5'd30 : md_dest;
  endfunction

  // Reference: which source owns the write port this cycle
  task automatic model_out();
    logic [4:0]  op;
    logic [4:0]  pd;
    bit          writing;
    op      = insn_in[31:27];
    writing = op inside {5'd0, 5'd12, 5'd5, 5'd8, 5'd3, 5'd21};
    if (op == 5'd3) pd = 5'd31;
    else if (write_exception || op == 5'd21) pd = 5'd30;
    else pd = insn_in[26:22];
    m_pw  = writing && (pd != 5'd0);
    m_byp = 1'b0;
    if (m_pw) begin
      m_we = 1'b1; m_reg = pd; m_data = (op == 5'd8) ? d_in : o_in;
    end else if (q.size() > 0) begin
      m_we = 1'b1; m_reg = q[0].dest; m_data = q[0].data;
    end else if (BYP && md_valid && md_final() != 5'd0) begin
      m_we = 1'b1; m_reg = md_final(); m_data = md_data; m_byp = 1'b1;
    end else begin
      m_we = 1'b0; m_reg = pd; m_data = o_in;
    end
  endtask

  task automatic settle();
    logic [31:0] m;
    @(negedge clock);
    model_out();
    chk("we", 64'(ctrl_writeEnable), 64'(m_we));
    chk("reg", 64'(ctrl_writeReg), 64'(m_reg));
    chk("data", 64'(data_writeReg), 64'(m_data));
    chk("md_ready", 64'(md_ready), 64'(q.size() < DEPTH));
    chk("count", 64'(fifo_count), 64'(q.size()));
    m = '0;
    foreach (q[i]) m[q[i].dest] = 1'b1;
    chk("mask", 64'(pending_mask), 64'(m));
  endtask

  task automatic tick();
    bit         acc;
    logic [4:0] mdd;
    model_out();
    mdd = md_final();
    acc = md_valid && (q.size() < DEPTH) && (mdd != 5'd0) && !m_byp;
    @(posedge clock);
    if (!m_pw && q.size() > 0) void'(q.pop_front());
    if (acc) q.push_back('{mdd, md_data});
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic pipe(logic [4:0] op, logic [4:0] rd, logic [31:0] o, logic [31:0] d, bit exc);
    insn_in = {op, rd, 22'($urandom)};
    o_in = o;
    d_in = d;
    write_exception = exc;
  endtask

  task automatic md(bit v, logic [4:0] dest, logic [31:0] data, bit exc);
    md_valid = v;
    md_dest = dest;
    md_data = data;
    md_exception = exc;
  endtask

  initial begin
    pipe(5'd2, 5'd0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("rst_we", 64'(ctrl_writeEnable), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_mask", 64'(pending_mask), 64'd0);
    chk("rst_ready", 64'(md_ready), 64'd1);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;

    // Pipeline-only writes
    pipe(5'd8, 5'd7, 32'h1, 32'hDEAD, 1'b0);
    settle();
    chk("lw_we", 64'(ctrl_writeEnable), 64'd1);
    chk("lw_reg", 64'(ctrl_writeReg), 64'd7);
    chk("lw_data", 64'(data_writeReg), 64'hDEAD);
    tick();
    pipe(5'd3, 5'd9, 32'h123, 32'h777, 1'b0);
    settle();
    chk("jal_reg", 64'(ctrl_writeReg), 64'd31);
    chk("jal_data", 64'(data_writeReg), 64'h123);
    tick();
    pipe(5'd5, 5'd4, 32'h44, 32'h0, 1'b1);
    settle();
    chk("exc_reg", 64'(ctrl_writeReg), 64'd30);
    tick();

    // r0 suppression
    pipe(5'd0, 5'd0, 32'h5, 32'h0, 1'b0);
    settle();
    chk("r0_we", 64'(ctrl_writeEnable), 64'd0);
    tick();
    pipe(5'd2, 5'd0, 32'h5, 32'h0, 1'b0);
    md(1'b1, 5'd0, 32'hAB, 1'b0);
    settle();
    chk("r0md_ready", 64'(md_ready), 64'd1);
    tick();
    md(1'b0, 5'd0, 32'h0, 1'b0);
    settle();
    chk("r0md_count", 64'(fifo_count), 64'd0);
    chk("r0md_we", 64'(ctrl_writeEnable), 64'd0);
    tick();

    // Drain waits behind a busy pipeline
    pipe(5'd0, 5'd3, 32'h33, 32'h0, 1'b0);
    md(1'b1, 5'd5, 32'h55, 1'b0);
    step();
    md(1'b0, 5'd0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("prio_count", 64'(fifo_count), 64'd1);
      chk("prio_mask5", 64'(pending_mask[5]), 64'd1);
      tick();
    end
    pipe(5'd2, 5'd3, 32'h0, 32'h0, 1'b0);
    settle();
    chk("drain_we", 64'(ctrl_writeEnable), 64'd1);
    chk("drain_reg", 64'(ctrl_writeReg), 64'd5);
    chk("drain_data", 64'(data_writeReg), 64'h55);
    tick();
    settle();
    chk("drain_count", 64'(fifo_count), 64'd0);
    chk("drain_mask", 64'(pending_mask), 64'd0);
    tick();

    // Fill to full, refuse a fifth, drain in order, then wrap
    pipe(5'd0, 5'd3, 32'h33, 32'h0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      md(1'b1, 5'(k), 32'h100 + 32'(k), 1'b0);
      step();
    end
    md(1'b1, 5'd6, 32'h106, 1'b0);
    settle();
    chk("full_ready", 64'(md_ready), 64'd0);
    tick();
    md(1'b0, 5'd0, 32'h0, 1'b0);
    pipe(5'd2, 5'd0, 32'h0, 32'h0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk("order_reg", 64'(ctrl_writeReg), 64'(k));
      chk("order_data", 64'(data_writeReg), 64'h100 + 64'(k));
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      md(1'b1, 5'(20 + k), 32'h200 + 32'(k), 1'b0);
      step();
    end
    md(1'b0, 5'd0, 32'h0, 1'b0);
    step();
    step();

    // Simultaneous push and pop at count 2
    pipe(5'd0, 5'd3, 32'h33, 32'h0, 1'b0);
    md(1'b1, 5'd12, 32'hC, 1'b1);
    step();
    md(1'b1, 5'd13, 32'hD, 1'b0);
    step();
    pipe(5'd2, 5'd0, 32'h0, 32'h0, 1'b0);
    md(1'b1, 5'd14, 32'hE, 1'b0);
    settle();
    chk("pp_count", 64'(fifo_count), 64'd2);
    chk("pp_reg30", 64'(ctrl_writeReg), 64'd30);
    chk("pp_data", 64'(data_writeReg), 64'hC);
    tick();
    md(1'b0, 5'd0, 32'h0, 1'b0);
    settle();
    chk("pp_count2", 64'(fifo_count), 64'd2);
    tick();
    step();
    step();

    // Asynchronous reset with three entries queued
    pipe(5'd0, 5'd3, 32'h33, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      md(1'b1, 5'(7 + k), 32'h70 + 32'(k), 1'b0);
      step();
    end
    md(1'b0, 5'd0, 32'h0, 1'b0);
    pipe(5'd2, 5'd0, 32'h0, 32'h0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mrst_we", 64'(ctrl_writeEnable), 64'd0);
    chk("mrst_count", 64'(fifo_count), 64'd0);
    chk("mrst_mask", 64'(pending_mask), 64'd0);
    chk("mrst_ready", 64'(md_ready), 64'd1);
    q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("post_rst_we", 64'(ctrl_writeEnable), 64'd0);
      tick();
    end

    // Idle-cycle md result: bypass or next-cycle write
    md(1'b1, 5'd9, 32'h99, 1'b0);
    settle();
`ifdef WB_MD_BYPASS_EN
    chk("byp_we", 64'(ctrl_writeEnable), 64'd1);
    chk("byp_reg", 64'(ctrl_writeReg), 64'd9);
    chk("byp_data", 64'(data_writeReg), 64'h99);
`else
    chk("nobyp_we", 64'(ctrl_writeEnable), 64'd0);
`endif
    tick();
    md(1'b0, 5'd0, 32'h0, 1'b0);
    settle();
`ifdef WB_MD_BYPASS_EN
    chk("byp_count", 64'(fifo_count), 64'd0);
    chk("byp_we2", 64'(ctrl_writeEnable), 64'd0);
`else
    chk("nobyp_we2", 64'(ctrl_writeEnable), 64'd1);
    chk("nobyp_reg", 64'(ctrl_writeReg), 64'd9);
    chk("nobyp_data", 64'(data_writeReg), 64'h99);
`endif
    tick();

    // Randomized traffic with varying pipeline write density
    begin
      int dens;
      dens = 50;
      for (int c = 0; c < 600; c++) begin
        if (c % 50 == 0) dens = (c / 50) % 3 == 0 ? 90 : ((c / 50) % 3 == 1 ? 15 : 50);
        if ($urandom_range(0, 99) < dens)
          pipe(wops[$urandom_range(0, 5)], 5'($urandom), $urandom, $urandom, $urandom_range(0, 9) == 0);
        else
          pipe(nops[$urandom_range(0, 5)], 5'($urandom), $urandom, $urandom, $urandom_range(0, 9) == 0);
        md($urandom_range(0, 9) < 6, 5'($urandom), $urandom, $urandom_range(0, 9) == 0);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
